// File: rtl/snn_pkg.sv
// snn_pkg: shared definitions for the SNN core wrapper and its output decoder.
//   state_t     classifier FSM encoding (IDLE/COUNT/DECIDE/DONE)
//   DEF_*       default N_OUT/T_WIN/CNT_W shared with the core wrapper
//   snn_clog2   ceil(log2(value)) for parameter arithmetic
//   snn_idx_w   class index width, never below 1
package snn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_DECIDE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int DEF_N_OUT = 2;
  localparam int DEF_T_WIN = 100;
  localparam int DEF_CNT_W = 8;

  function automatic int snn_clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int snn_idx_w(input int n);
    return (n > 1) ? snn_clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spike_argmax.sv
// spike_argmax: combinational argmax over per-neuron spike counts.
//   counts      in   N_OUT x CNT_W    saturated spike counts
//   first_step  in   N_OUT x STEP_W   first-spike timestep, all-ones = never
//                                     (only with FIRST_SPIKE_TIEBREAK_EN)
//   idx         out  IDX_W            winning neuron
//   max_count   out  CNT_W            count of the winner
//   tie         out  1                two or more neurons share the maximum count
// Equal counts resolve to the lowest index, or with FIRST_SPIKE_TIEBREAK_EN
// defined to the earliest first spike and then the lowest index.
module spike_argmax
  import snn_pkg::*;
#(
  parameter int N_OUT  = DEF_N_OUT,
  parameter int CNT_W  = DEF_CNT_W,
`ifdef FIRST_SPIKE_TIEBREAK_EN
  parameter int STEP_W = 7,
`endif
  parameter int IDX_W  = snn_idx_w(N_OUT)
) (
  input  logic [N_OUT-1:0][CNT_W-1:0]  counts,
`ifdef FIRST_SPIKE_TIEBREAK_EN
  input  logic [N_OUT-1:0][STEP_W-1:0] first_step,
`endif
  output logic [IDX_W-1:0]             idx,
  output logic [CNT_W-1:0]             max_count,
  output logic                         tie
);

  int n_eq;

  always_comb begin
    idx       = '0;
    max_count = counts[0];
    tie       = 1'b0;
    n_eq      = 0;
`ifdef FIRST_SPIKE_TIEBREAK_EN
    for (int i = 1; i < N_OUT; i++) begin
      // Ascending scan with strict compares keeps the lowest index on a full tie.
      if ((counts[i] > max_count) ||
          ((counts[i] == max_count) && (first_step[i] < first_step[idx]))) begin
        idx       = IDX_W'(i);
        max_count = counts[i];
      end
    end
`else
    for (int i = 1; i < N_OUT; i++) begin
      if (counts[i] > max_count) begin
        idx       = IDX_W'(i);
        max_count = counts[i];
      end
    end
`endif
    for (int i = 0; i < N_OUT; i++) begin
      if (counts[i] == max_count) n_eq = n_eq + 1;
    end
    tie = (n_eq > 1);
  end

endmodule

// File: rtl/spike_count_classifier.sv
// spike_count_classifier: counts layer-2 output spikes per neuron over T_WIN
// timestep pulses and reports the argmax class through valid/ready.
//   clk           in   1       system clock, rising edge
//   reset         in   1       asynchronous, active-low reset
//   pulse         in   1       timestep strobe
//   start         in   1       begin a window (accepted only in IDLE)
//   spk_in        in   N_OUT   spikes, sampled only when pulse=1 in COUNT
//   busy          out  1       state != IDLE
//   result_valid  out  1       result held until result_ready
//   result_ready  in   1       consumer accept
//   class_idx     out  IDX_W   winning neuron
//   tie           out  1       maximum count shared by two or more neurons
//   win_count     out  CNT_W   winning count
// Optional macro FIRST_SPIKE_TIEBREAK_EN: count ties broken by earliest first spike.
//
// state  | meaning
// IDLE   | waiting for start, counters cleared
// COUNT  | accumulating spikes on each pulse until T_WIN pulses seen
// DECIDE | argmax registered into the result outputs
// DONE   | result_valid held until result_ready
module spike_count_classifier
  import snn_pkg::*;
#(
  parameter int N_OUT = DEF_N_OUT,
  parameter int T_WIN = DEF_T_WIN,
  parameter int CNT_W = DEF_CNT_W,
  parameter int IDX_W = snn_idx_w(N_OUT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pulse,
  input  logic             start,
  input  logic [N_OUT-1:0] spk_in,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [IDX_W-1:0] class_idx,
  output logic             tie,
  output logic [CNT_W-1:0] win_count
);

  localparam int                STEP_W    = snn_clog2(T_WIN + 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(T_WIN - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_t                         state_q, state_d;
  logic [N_OUT-1:0][CNT_W-1:0]    cnt_q;
  logic [STEP_W-1:0]              step_q;
  logic                           count_en;
  logic                           last_pulse;
  logic                           clear_win;
  logic [IDX_W-1:0]               am_idx;
  logic [CNT_W-1:0]               am_max;
  logic                           am_tie;

  assign count_en   = (state_q == ST_COUNT) && pulse;
  assign last_pulse = count_en && (step_q == STEP_LAST);
  assign clear_win  = (state_q == ST_DONE) && result_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    busy         = (state_q != ST_IDLE);
    result_valid = (state_q == ST_DONE);
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_COUNT;
      ST_COUNT:  if (last_pulse) state_d = ST_DECIDE;
      ST_DECIDE: state_d = ST_DONE;
      ST_DONE:   if (result_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      step_q <= '0;
    end else if (clear_win) begin
      cnt_q  <= '0;
      step_q <= '0;
    end else if (count_en) begin
      step_q <= step_q + 1'b1;
      for (int i = 0; i < N_OUT; i++) begin
        if (spk_in[i] && (cnt_q[i] != CNT_MAX)) cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

`ifdef FIRST_SPIKE_TIEBREAK_EN
  // All-ones marks "never spiked"; recorded steps never exceed T_WIN-1.
  logic [N_OUT-1:0][STEP_W-1:0] first_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      first_q <= '1;
    end else if (clear_win) begin
      first_q <= '1;
    end else if (count_en) begin
      for (int i = 0; i < N_OUT; i++) begin
        if (spk_in[i] && (first_q[i] == '1)) first_q[i] <= step_q;
      end
    end
  end

  spike_argmax #(
    .N_OUT  (N_OUT),
    .CNT_W  (CNT_W),
    .STEP_W (STEP_W),
    .IDX_W  (IDX_W)
  ) u_argmax (
    .counts     (cnt_q),
    .first_step (first_q),
    .idx        (am_idx),
    .max_count  (am_max),
    .tie        (am_tie)
  );
`else
  spike_argmax #(
    .N_OUT (N_OUT),
    .CNT_W (CNT_W),
    .IDX_W (IDX_W)
  ) u_argmax (
    .counts    (cnt_q),
    .idx       (am_idx),
    .max_count (am_max),
    .tie       (am_tie)
  );
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      class_idx <= '0;
      tie       <= 1'b0;
      win_count <= '0;
    end else if (state_q == ST_DECIDE) begin
      class_idx <= am_idx;
      tie       <= am_tie;
      win_count <= am_max;
    end
  end

endmodule
